enum_word_deser: RTL and testbench

- Receive-side counterpart of the packed-enum word producers: reassembles one 90-bit packed word (the bit-width shared by all logic/bit[89:0] enum union members) from a stream of 32-bit (int-width) beats.
- Checks framing and pad bits, presents the word on a valid/ready output, and keeps saturating good/error word counts.
- All internal state (FSM, beat index) uses enums with explicit bases; the block doubles as an enum-width regression design for the frontend.

---
 rtl/enum_deser_pkg.sv | 30 +++
 rtl/enum_word_deser_sat_counter.sv | 17 +
 rtl/enum_word_deser.sv | 121 ++++++++++++
 tb/tb_enum_word_deser.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_deser_pkg.sv
// Shared types and widths for the 90-bit packed-word deserialiser.
// The word width is spelled through PAD_PARAM so enum/union width handling gets exercised.
package enum_deser_pkg;
  localparam int PAD_PARAM = 4;
  localparam int WORD_W    = 86 + PAD_PARAM;
  localparam int BEAT_W    = 32;
  localparam int NUM_BEATS = (WORD_W + BEAT_W - 1) / BEAT_W;
  localparam int LAST_W    = WORD_W - (NUM_BEATS - 1) * BEAT_W;

  typedef bit [85 + PAD_PARAM:0] word_t;
  typedef int beat_t;

  typedef enum logic [1:0] {
    BEAT_0 = 2'd0,
    BEAT_1 = 2'd1,
    BEAT_2 = 2'd2
  } beat_idx_e;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HOLD = 2'd1
  } out_state_e;

  typedef union packed {
    word_t                                       raw;
    bit [NUM_BEATS-1:0][WORD_W/NUM_BEATS-1:0]   lanes;
  } word_u;

  localparam beat_idx_e LAST_IDX = beat_idx_e'(NUM_BEATS - 1);
endpackage

// File: rtl/enum_word_deser_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/enum_word_deser.sv
// Reassembles a 90-bit word from 32-bit beats, flags framing/pad errors,
// presents it on valid/ready and keeps saturating good/error word counts.
module enum_word_deser
  import enum_deser_pkg::*;
#(
  parameter int OK_CNT_W  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BEAT_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic                 out_err,
  output logic [OK_CNT_W-1:0]  ok_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  if ($bits(word_t) != 90 || $bits(word_u) != 90) begin : g_width_chk
    $error("enum_word_deser: packed word width is not 90 bits");
  end

  beat_idx_e          r_idx;
  out_state_e         r_state;
  out_state_e         w_state_nxt;
  logic [WORD_W-1:0]  r_acc;
  logic [WORD_W-1:0]  r_word;
  logic               r_err;
  logic [WORD_W-1:0]  w_merged;
  logic               w_is_last_idx;
  logic               w_ends_word;
  logic               w_accept;
  logic               w_complete;
  logic               w_pop;
  logic               w_pad_bad;
  logic               w_err;

  assign out_valid     = (r_state == S_HOLD);
  assign out_word      = r_word;
  assign out_err       = r_err;
  assign w_is_last_idx = (r_idx == LAST_IDX);
  assign w_ends_word   = w_is_last_idx || in_last;
  assign w_pop         = out_valid && out_ready;

  // Any word-ending beat (final index or early in_last) needs the output register free.
  assign in_ready      = !(w_ends_word && out_valid && !out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_complete    = w_accept && w_ends_word;

  assign w_pad_bad     = w_is_last_idx && (in_data[BEAT_W-1:LAST_W] != '0);
  assign w_err         = !w_is_last_idx || !in_last || w_pad_bad;

  always_comb begin
    w_merged = r_acc;
    case (r_idx)
      BEAT_0:  w_merged[0 +: BEAT_W]         = in_data;
      BEAT_1:  w_merged[BEAT_W +: BEAT_W]    = in_data;
      default: w_merged[WORD_W-1 -: LAST_W]  = in_data[LAST_W-1:0];
    endcase
  end

  // Accumulator is cleared on completion so a short word has zero upper bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= BEAT_0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_ends_word) begin
        r_idx <= BEAT_0;
        r_acc <= '0;
      end else begin
        r_idx <= beat_idx_e'(r_idx + 2'd1);
        r_acc <= w_merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_err  <= 1'b0;
    end else if (w_complete) begin
      r_word <= w_merged;
      r_err  <= w_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_complete) begin
      w_state_nxt = S_HOLD;
    end else if (w_pop) begin
      w_state_nxt = S_FILL;
    end
  end

  sat_counter #(.W(OK_CNT_W)) u_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_pop && !r_err),
    .count (ok_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_pop && r_err),
    .count (err_cnt)
  );
endmodule

// File: tb/tb_enum_word_deser.sv
// Scoreboard bench for enum_word_deser: expected words queued at drive time,
// received words captured at the output handshake and compared in order.
module tb_enum_word_deser;
  typedef struct packed {
    logic [89:0] w;
    logic        e;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [89:0] out_word;
  logic        out_err;
  logic [15:0] ok_cnt;
  logic [7:0]  err_cnt;

  int   checks = 0;
  int   errors = 0;
  int   exp_ok = 0;
  int   exp_err = 0;
  rec_t exp_q[$];
  rec_t rx_q[$];

  enum_word_deser #(.OK_CNT_W(16), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rx_q.push_back({out_word, out_err});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic rec_t model(input logic [31:0] b0, input logic [31:0] b1,
                                 input logic [31:0] b2, input int n, input logic lastf);
    rec_t r;
    r.w = '0;
    r.w[31:0] = b0;
    if (n >= 2) r.w[63:32] = b1;
    if (n >= 3) r.w[89:64] = b2[25:0];
    r.e = (n < 3) ? 1'b1 : (!lastf || (b2[31:26] != 6'd0));
    return r;
  endfunction

  task automatic push_exp(input rec_t r);
    exp_q.push_back(r);
    if (r.e) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    else     exp_ok  = (exp_ok < 65535) ? exp_ok + 1 : 65535;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL beat_timeout in_ready got 0 want 1");
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input int n, input logic lastf);
    push_exp(model(b0, b1, b2, n, lastf));
    send_beat(b0, n == 1);
    if (n >= 2) send_beat(b1, n == 2);
    if (n >= 3) send_beat(b2, lastf);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_word !== 90'h0) begin errors++; $display("FAIL rst_word got %h want 0", out_word); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", out_err); end
    checks++; if (ok_cnt !== 16'h0) begin errors++; $display("FAIL rst_ok got %h want 0", ok_cnt); end
    checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL rst_errcnt got %h want 0", err_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    rec_t e, r;
    bit ok;
    out_ready = 1'b1;
    send_word(32'h1, 32'h2, 32'h3, 3, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", out_valid); end
    checks++; if (out_word !== 90'h3_0000_0002_0000_0001) begin errors++; $display("FAIL basic_word got %h want 3_0000_0002_0000_0001", out_word); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", out_err); end
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL basic_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
    checks++; if (ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL basic_okcnt got %0d want %0d", ok_cnt, exp_ok); end
  endtask

  task automatic test_pad();
    rec_t e, r;
    bit ok;
    send_word(32'h10, 32'h20, 32'hFC00_0005, 3, 1'b1);
    checks++; if (out_word[89:64] !== 26'h5) begin errors++; $display("FAIL pad_top got %h want 5", out_word[89:64]); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL pad_err got %b want 1", out_err); end
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL pad_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL pad_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL pad_errcnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_early();
    rec_t e, r;
    bit ok;
    send_word(32'hAAAA_AAAA, 32'h0, 32'h0, 1, 1'b1);
    checks++; if (out_word !== 90'hAAAA_AAAA) begin errors++; $display("FAIL early_word got %h want AAAAAAAA", out_word); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL early_err got %b want 1", out_err); end
    send_word(32'h4, 32'h5, 32'h6, 3, 1'b1);
    send_word(32'h7, 32'h8, 32'h9, 3, 1'b0);
    send_word(32'hA, 32'hB, 32'hC, 3, 1'b1);
    send_word(32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 2, 1'b1);
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL early_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
    checks++; if (ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL early_okcnt got %0d want %0d", ok_cnt, exp_ok); end
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL early_errcnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_back_to_back();
    rec_t e, r;
    bit ok;
    time t0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    t0 = $time;
    for (int k = 0; k < 3; k++) begin
      send_word(32'(16 * k + 1), 32'(16 * k + 2), 32'(16 * k + 3), 3, 1'b1);
    end
    checks++; if (($time - t0) !== 90) begin errors++; $display("FAIL b2b_time got %0t want 90", $time - t0); end
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL b2b_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
  endtask

  task automatic test_backpressure();
    rec_t e, r, ra;
    bit ok;
    ra = model(32'h100, 32'h101, 32'h102, 3, 1'b1);
    out_ready = 1'b0;
    send_word(32'h100, 32'h101, 32'h102, 3, 1'b1);
    fork
      send_word(32'h200, 32'h201, 32'h202, 3, 1'b1);
      begin
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
        checks++; if (out_word !== ra.w) begin errors++; $display("FAIL bp_hold1 got %h want %h", out_word, ra.w); end
        repeat (2) @(negedge clk);
        checks++; if (out_word !== ra.w) begin errors++; $display("FAIL bp_hold2 got %h want %h", out_word, ra.w); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL bp_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
  endtask

  task automatic test_saturation();
    rec_t e, r;
    bit ok;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send_word($urandom, 32'h0, 32'h0, 1, 1'b1);
    end
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL sat_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_errcnt got %h want ff", err_cnt); end
    checks++; if (ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL sat_okcnt got %0d want %0d", ok_cnt, exp_ok); end
  endtask

  task automatic test_reset_mid();
    rec_t e, r;
    bit ok;
    out_ready = 1'b0;
    send_word(32'h31, 32'h32, 32'h33, 3, 1'b1);
    send_beat(32'h41, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    checks++; if (out_word !== 90'h0) begin errors++; $display("FAIL rmid_word got %h want 0", out_word); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", out_err); end
    checks++; if (ok_cnt !== 16'h0) begin errors++; $display("FAIL rmid_ok got %h want 0", ok_cnt); end
    checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL rmid_errcnt got %h want 0", err_cnt); end
    exp_q.delete();
    rx_q.delete();
    exp_ok  = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h51, 32'h52, 32'h53, 3, 1'b1);
    wait_rx(exp_q.size(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_rx got %0d want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL rmid_sb got %h/%b want %h/%b", r.w, r.e, e.w, e.e); end
    end
    checks++; if (ok_cnt !== 16'h1) begin errors++; $display("FAIL rmid_okcnt got %0d want 1", ok_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_early();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
